n_reg: RTL and testbench



---
 rtl/n_reg.sv | 64 ++++++
 tb/tb_n_reg.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/n_reg.sv
// n_reg: parameterised-width storage register.
//   - Q updates to D on a rising CLOCK edge when Load is high, and holds otherwise.
//   - Clear is asynchronous and active-high. It forces Q to RESET_VALUE and overrides Load.
//   - Q comes straight from the flops. There is no combinational path from D or Load.
// Optional feature: define N_REG_XCHECK_EN to add simulation-only X/Z checking
// on Load, D and Clear. This checking is not part of the synthesised logic.
`timescale 1ns/1ps

module n_reg #(
    parameter int          WIDTH       = 8,
    parameter logic [63:0] RESET_VALUE = '0
) (
    input  logic             CLOCK,
    input  logic             Load,
    input  logic             Clear,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    // RESET_VALUE is carried at the full 64-bit legal maximum, then truncated to the instance width.
    localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];

    logic [WIDTH-1:0] q_reg;

`ifdef N_REG_XCHECK_EN
    // Storage: a clear wins outright. An unknown Load poisons the contents, so a
    // bad enable cannot hide behind a stale value.
    always_ff @(posedge CLOCK or posedge Clear) begin
        if (Clear)
            q_reg <= RST_VAL;
        else if ($isunknown(Load))
            q_reg <= {WIDTH{1'bx}};
        else if (Load)
            q_reg <= D;
    end

    // Edge-time input checks. These only apply while the register is out of clear.
    always @(posedge CLOCK) begin
        if (Clear === 1'b0) begin
            if ($isunknown(Load))
                $error("%m: Load is X/Z at rising edge, t=%0t", $time);
            else if (Load && $isunknown(D))
                $warning("%m: D has X/Z bits while loading, t=%0t", $time);
        end
    end

    // Clear is level-sensitive and asynchronous, so it is watched continuously rather than only at edges.
    always @(Clear) begin
        if ($isunknown(Clear))
            $error("%m: Clear is X/Z, t=%0t", $time);
    end
`else
    // Storage: an asynchronous clear takes priority. Otherwise the register loads on enable and holds without it.
    always_ff @(posedge CLOCK or posedge Clear) begin
        if (Clear)
            q_reg <= RST_VAL;
        else if (Load)
            q_reg <= D;
    end
`endif

    assign Q = q_reg;

endmodule

// File: tb/tb_n_reg.sv
// tb_n_reg: testbench for three n_reg instances.
//   - 8-bit instance with the default reset value.
//   - 16-bit instance with the default reset value.
//   - 8-bit instance with RESET_VALUE = 0xA5.
// Clock period is 2 ns, with rising edges at odd ns.
// A directed table runs first, then hand-written async-clear sequences, then
// random cycles checked against a reference model.
`timescale 1ns/1ps

module tb_n_reg;

    localparam logic [7:0] RV = 8'hA5;

    logic        clk;
    logic        load;
    logic        clear;
    logic [7:0]  d8;
    logic [15:0] d16;
    logic [7:0]  q8;
    logic [15:0] q16;
    logic [7:0]  qrv;

    int checks = 0;
    int errors = 0;

    n_reg #(.WIDTH(8)) u8 (
        .CLOCK(clk), .Load(load), .Clear(clear), .D(d8), .Q(q8)
    );
    n_reg #(.WIDTH(16)) u16 (
        .CLOCK(clk), .Load(load), .Clear(clear), .D(d16), .Q(q16)
    );
    n_reg #(.WIDTH(8), .RESET_VALUE(64'hA5)) urv (
        .CLOCK(clk), .Load(load), .Clear(clear), .D(d8), .Q(qrv)
    );

    // Clock starts low, so the first rising edge is at 1 ns.
    initial begin
        clk = 1'b0;
        forever #1 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        clr;
        logic        ld;
        logic [7:0]  d8;
        logic [15:0] d16;
        logic [7:0]  e8;
        logic [15:0] e16;
        logic [7:0]  erv;
    } vec_t;

    vec_t vt [10];

    // Reference model state: the value each register must hold.
    logic [7:0]  m8;
    logic [15:0] m16;
    logic [7:0]  mrv;

    initial begin
        vt[0] = '{1'b1, 1'b0, 8'h0F, 16'hF0F0, 8'h00, 16'h0000, RV};    // clear holds across edges
        vt[1] = '{1'b1, 1'b1, 8'h0F, 16'hF0F0, 8'h00, 16'h0000, RV};    // clear beats load
        vt[2] = '{1'b0, 1'b1, 8'h0F, 16'hF0F0, 8'h0F, 16'hF0F0, 8'h0F}; // first load
        vt[3] = '{1'b0, 1'b0, 8'h09, 16'h00FF, 8'h0F, 16'hF0F0, 8'h0F}; // hold, D ignored
        vt[4] = '{1'b0, 1'b0, 8'h09, 16'h00FF, 8'h0F, 16'hF0F0, 8'h0F};
        vt[5] = '{1'b0, 1'b1, 8'h09, 16'h00FF, 8'h09, 16'h00FF, 8'h09}; // reload
        vt[6] = '{1'b0, 1'b1, 8'h09, 16'h00FF, 8'h09, 16'h00FF, 8'h09}; // stable with constant D
        vt[7] = '{1'b0, 1'b0, 8'h55, 16'hAAAA, 8'h09, 16'h00FF, 8'h09};
        vt[8] = '{1'b0, 1'b1, 8'hFF, 16'hFFFF, 8'hFF, 16'hFFFF, 8'hFF}; // all ones
        vt[9] = '{1'b0, 1'b1, 8'h00, 16'h0000, 8'h00, 16'h0000, 8'h00}; // back-to-back load of zero

        // Reset: Clear acts with no clock edge.
        clear = 1'b1; load = 1'b0; d8 = 8'h0F; d16 = 16'hF0F0;
        #0.5;
        chk("reset_q8", 64'(q8), 64'h00);
        chk("reset_q16", 64'(q16), 64'h0000);
        chk("reset_qrv", 64'(qrv), 64'(RV));

        // Table: drive at the falling edge, check at the following falling edge.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            clear = vt[i].clr; load = vt[i].ld; d8 = vt[i].d8; d16 = vt[i].d16;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_q8", i), 64'(q8), 64'(vt[i].e8));
            chk($sformatf("vec%0d_q16", i), 64'(q16), 64'(vt[i].e16));
            chk($sformatf("vec%0d_qrv", i), 64'(qrv), 64'(vt[i].erv));
        end

        // Q has no combinational path from D: change D mid-cycle and Q must not move.
        // At this point we are at a falling edge and Q = 0.
        load = 1'b1; d8 = 8'h3C; d16 = 16'h1234;
        #0.5;
        chk("nocomb_q8", 64'(q8), 64'h00);
        chk("nocomb_q16", 64'(q16), 64'h0000);
        @(posedge clk); #0.5;
        chk("load3c_q8", 64'(q8), 64'h3C);
        chk("load3c_qrv", 64'(qrv), 64'h3C);

        // Async clear mid-operation, with Load high throughout.
        @(negedge clk);
        #0.2 clear = 1'b1;
        #0.2;
        chk("aclr_q8", 64'(q8), 64'h00);
        chk("aclr_q16", 64'(q16), 64'h0000);
        chk("aclr_qrv", 64'(qrv), 64'(RV));
        repeat (2) @(posedge clk);
        #0.5;
        chk("aclr_hold_q8", 64'(q8), 64'h00);
        chk("aclr_hold_qrv", 64'(qrv), 64'(RV));

        // Release Clear. The first edge with Clear low loads normally.
        @(negedge clk);
        clear = 1'b0; d8 = 8'h3C; d16 = 16'hBEEF;
        @(posedge clk); #0.5;
        chk("release_q8", 64'(q8), 64'h3C);
        chk("release_q16", 64'(q16), 64'hBEEF);
        chk("release_qrv", 64'(qrv), 64'h3C);

        // Short clear pulse entirely between edges. Q then stays at reset until the next loading edge.
        load = 1'b0;
        #0.2 clear = 1'b1;
        #0.2 clear = 1'b0;
        @(posedge clk); #0.5;
        chk("pulse_q8", 64'(q8), 64'h00);
        chk("pulse_qrv", 64'(qrv), 64'(RV));

        // Random cycles against the reference model.
        m8 = q8; m16 = q16; mrv = qrv;
        // Seed the model from the already-checked state above.
        m8 = 8'h00; m16 = 16'h0000; mrv = RV;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            clear = ($urandom_range(0, 7) == 0);
            load  = 1'($urandom_range(0, 1));
            d8    = 8'($urandom);
            d16   = 16'($urandom);
            @(posedge clk);
            if (clear) begin
                m8 = 8'h00; m16 = 16'h0000; mrv = RV;
            end else if (load) begin
                m8 = d8; m16 = d16; mrv = d8;
            end
            #0.5;
            chk("rand_q8", 64'(q8), 64'(m8));
            chk("rand_q16", 64'(q16), 64'(m16));
            chk("rand_qrv", 64'(qrv), 64'(mrv));
            if (!clear && $urandom_range(0, 9) == 0) begin
                #0.1 clear = 1'b1;
                #0.1;
                m8 = 8'h00; m16 = 16'h0000; mrv = RV;
                chk("rand_pulse_q8", 64'(q8), 64'(m8));
                chk("rand_pulse_qrv", 64'(qrv), 64'(mrv));
                clear = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
